// File: rtl/ring_checker.sv
// ring_checker: receive-side checker for an N-stage one-hot ring counter.
// Decodes the token position, acquires lock on a consistent rotation,
// tracks its direction and flags lost, duplicated or skipped tokens.
module ring_checker #(
    parameter int N          = 5,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 2
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [N-1:0]         ring_in,
    input  logic                 in_valid,
    output logic [$clog2(N)-1:0] pos,
    output logic                 pos_valid,
    output logic                 locked,
    output logic                 dir,
    output logic                 err,
    output logic [7:0]           err_total
);

    localparam int PW   = $clog2(N);
    localparam int CNTW = $clog2(N + 1);
    localparam int CW   = $clog2(LOCK_COUNT + 1);
    localparam int EW   = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   prev_idx, prev_idx_n;
    logic [CW-1:0]   match_cnt, match_cnt_n;
    logic [EW-1:0]   err_cnt, err_cnt_n;
    logic            acq_dir, acq_dir_n;
    logic [PW-1:0]   pos_n;
    logic            pos_valid_n, locked_n, dir_n, err_n;
    logic [7:0]      err_total_n;

    logic [CNTW-1:0] bit_cnt;
    logic [PW-1:0]   dec_idx;
    logic            is_onehot;
    logic [PW-1:0]   nxt_up, nxt_dn, exp_idx;
    logic [N-1:0]    exp_word;
    logic            acq_ok, acq_done, lock_hit, err_last, first_dir;

    // Neighbour of index i in the given direction, wrapping at both ends.
    function automatic logic [PW-1:0] step_idx(input logic [PW-1:0] i, input logic d);
        if (!d) return (i == PW'(N - 1)) ? '0 : i + PW'(1);
        else    return (i == '0) ? PW'(N - 1) : i - PW'(1);
    endfunction

    // Population count and position of the (last) set bit of the ring word.
    always_comb begin
        bit_cnt = '0;
        dec_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ring_in[i]) begin
                bit_cnt = bit_cnt + CNTW'(1);
                dec_idx = PW'(i);
            end
        end
    end

    assign is_onehot = (bit_cnt == CNTW'(1));
    assign nxt_up    = step_idx(prev_idx, 1'b0);
    assign nxt_dn    = step_idx(prev_idx, 1'b1);
    assign exp_idx   = dir ? nxt_dn : nxt_up;
    assign exp_word  = {{(N-1){1'b0}}, 1'b1} << exp_idx;
    assign lock_hit  = (ring_in == exp_word);
    assign err_last  = (err_cnt == EW'(ERR_LIMIT - 1));
    // On the second word either neighbour is acceptable; it fixes the direction.
    // For N=2 both neighbours coincide and the direction resolves to 0.
    assign first_dir = (dec_idx != nxt_up);
    assign acq_ok    = is_onehot &&
                       ((match_cnt == CW'(1)) ? (dec_idx == nxt_up || dec_idx == nxt_dn)
                                              : (dec_idx == (acq_dir ? nxt_dn : nxt_up)));
    assign acq_done  = acq_ok && (match_cnt == CW'(LOCK_COUNT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (clear) state <= HUNT;
        else       state <= state_nxt;
    end

    // Next-state: HUNT -> ACQ on any token, ACQ -> LOCKED after a consistent run,
    // LOCKED -> HUNT after ERR_LIMIT consecutive faults.
    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            case (state)
                HUNT:    if (is_onehot) state_nxt = ACQ;
                ACQ:     if (!is_onehot) state_nxt = HUNT;
                         else if (acq_done) state_nxt = LOCKED;
                LOCKED:  if (!lock_hit && err_last) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Next values of the tracking state and the registered outputs.
    always_comb begin
        prev_idx_n  = prev_idx;
        match_cnt_n = match_cnt;
        err_cnt_n   = err_cnt;
        acq_dir_n   = acq_dir;
        pos_n       = pos;
        pos_valid_n = 1'b0;
        locked_n    = locked;
        dir_n       = dir;
        err_n       = 1'b0;
        err_total_n = err_total;
        if (in_valid) begin
            // Any one-hot word reports its position, whether expected or not.
            if (is_onehot) begin
                pos_n       = dec_idx;
                pos_valid_n = 1'b1;
            end
            case (state)
                HUNT: begin
                    if (is_onehot) begin
                        prev_idx_n  = dec_idx;
                        match_cnt_n = CW'(1);
                    end
                end
                ACQ: begin
                    if (!is_onehot) begin
                        match_cnt_n = '0;
                    end else if (acq_ok) begin
                        prev_idx_n  = dec_idx;
                        match_cnt_n = match_cnt + CW'(1);
                        if (match_cnt == CW'(1)) acq_dir_n = first_dir;
                        if (acq_done) begin
                            locked_n  = 1'b1;
                            dir_n     = (match_cnt == CW'(1)) ? first_dir : acq_dir;
                            err_cnt_n = '0;
                        end
                    end else begin
                        // Inconsistent token: start a new run from here.
                        prev_idx_n  = dec_idx;
                        match_cnt_n = CW'(1);
                    end
                end
                LOCKED: begin
                    // Track free-runs along the expected rotation even on faults.
                    prev_idx_n = exp_idx;
                    if (lock_hit) begin
                        err_cnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                        if (err_total != 8'hFF) err_total_n = err_total + 8'd1;
                        if (err_last) begin
                            locked_n    = 1'b0;
                            dir_n       = 1'b0;
                            match_cnt_n = '0;
                            err_cnt_n   = '0;
                        end else begin
                            err_cnt_n = err_cnt + EW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            prev_idx  <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            acq_dir   <= 1'b0;
            pos       <= '0;
            pos_valid <= 1'b0;
            locked    <= 1'b0;
            dir       <= 1'b0;
            err       <= 1'b0;
            err_total <= '0;
        end else begin
            prev_idx  <= prev_idx_n;
            match_cnt <= match_cnt_n;
            err_cnt   <= err_cnt_n;
            acq_dir   <= acq_dir_n;
            pos       <= pos_n;
            pos_valid <= pos_valid_n;
            locked    <= locked_n;
            dir       <= dir_n;
            err       <= err_n;
            err_total <= err_total_n;
        end
    end

endmodule

// File: tb/tb_ring_checker.sv
// Self-checking bench for ring_checker (N=5, LOCK_COUNT=3, ERR_LIMIT=2).
module tb_ring_checker;

    localparam int N  = 5;
    localparam int LC = 3;
    localparam int EL = 2;

    logic         clk = 1'b0;
    logic         clear = 1'b1;
    logic [N-1:0] ring_in = '0;
    logic         in_valid = 1'b0;
    logic [2:0]   pos;
    logic         pos_valid, locked, dir, err;
    logic [7:0]   err_total;

    ring_checker #(.N(N), .LOCK_COUNT(LC), .ERR_LIMIT(EL)) dut (
        .clk(clk), .clear(clear), .ring_in(ring_in), .in_valid(in_valid),
        .pos(pos), .pos_valid(pos_valid), .locked(locked), .dir(dir),
        .err(err), .err_total(err_total)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       clr;
        bit       vld;
        bit [4:0] ring;
        int       pos;
        bit       pv;
        bit       lk;
        bit       dr;
        bit       er;
        int       tot;
    } vec_t;

    vec_t tbl[$];

    // Reference model: acquisition run kept as a queue of indices.
    int m_q[$];
    int m_step, m_prev, m_run, m_pos, m_tot;
    bit m_locked, m_dir, m_pv, m_err;

    task automatic model_update(input bit c, input bit v, input bit [4:0] r);
        int ones, idx, d, st, e;
        if (c) begin
            m_q.delete(); m_step = 0; m_prev = 0; m_run = 0; m_pos = 0; m_tot = 0;
            m_locked = 0; m_dir = 0; m_pv = 0; m_err = 0;
            return;
        end
        m_pv = 0; m_err = 0;
        if (!v) return;
        ones = $countones(r);
        idx = 0;
        for (int i = 0; i < N; i++) if (r[i]) idx = i;
        if (!m_locked) begin
            if (ones == 1) begin
                m_pos = idx; m_pv = 1;
                if (m_q.size() == 0) m_q.push_back(idx);
                else begin
                    d = (idx - m_q[$] + N) % N;
                    st = (d == 1) ? 1 : (d == N - 1) ? -1 : 0;
                    if (st != 0 && (m_q.size() == 1 || st == m_step)) begin
                        if (m_q.size() == 1) m_step = st;
                        m_q.push_back(idx);
                    end else begin
                        m_q.delete(); m_q.push_back(idx);
                    end
                end
                if (m_q.size() == LC) begin
                    m_locked = 1; m_dir = (m_step == -1); m_prev = idx; m_run = 0;
                    m_q.delete();
                end
            end else m_q.delete();
        end else begin
            e = (m_prev + (m_dir ? N - 1 : 1)) % N;
            m_prev = e;
            if (ones == 1) begin m_pos = idx; m_pv = 1; end
            if (ones == 1 && idx == e) m_run = 0;
            else begin
                m_err = 1;
                if (m_tot < 255) m_tot++;
                m_run++;
                if (m_run == EL) begin m_locked = 0; m_dir = 0; m_run = 0; end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit c, input bit v, input bit [4:0] r);
        clear = c; in_valid = v; ring_in = r;
        @(posedge clk);
        model_update(c, v, r);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".pos"}, int'(pos), m_pos);
        chk({tag, ".pos_valid"}, int'(pos_valid), int'(m_pv));
        chk({tag, ".locked"}, int'(locked), int'(m_locked));
        chk({tag, ".dir"}, int'(dir), int'(m_locked ? m_dir : 1'b0));
        chk({tag, ".err"}, int'(err), int'(m_err));
        chk({tag, ".err_total"}, int'(err_total), m_tot);
    endtask

    task automatic add(input bit c, input bit v, input bit [4:0] r, input int p,
                       input bit pv, input bit lk, input bit dr, input bit er, input int t);
        vec_t x;
        x.clr = c; x.vld = v; x.ring = r; x.pos = p; x.pv = pv;
        x.lk = lk; x.dr = dr; x.er = er; x.tot = t;
        tbl.push_back(x);
    endtask

    initial begin
        int tok, r, k;
        bit gd, v;
        bit [4:0] w;
        // clr vld ring      pos pv lk dr er tot
        add(1, 1, 5'b11111, 0, 0, 0, 0, 0, 0);
        add(1, 1, 5'b11111, 0, 0, 0, 0, 0, 0);
        add(0, 1, 5'b00000, 0, 0, 0, 0, 0, 0);
        add(0, 1, 5'b00001, 0, 1, 0, 0, 0, 0);
        add(0, 1, 5'b00010, 1, 1, 0, 0, 0, 0);
        add(0, 1, 5'b00100, 2, 1, 1, 0, 0, 0);
        add(0, 1, 5'b01000, 3, 1, 1, 0, 0, 0);
        add(0, 1, 5'b10000, 4, 1, 1, 0, 0, 0);
        add(0, 1, 5'b00001, 0, 1, 1, 0, 0, 0);
        add(0, 1, 5'b00010, 1, 1, 1, 0, 0, 0);
        add(0, 0, 5'b11111, 1, 0, 1, 0, 0, 0);
        add(0, 1, 5'b00100, 2, 1, 1, 0, 0, 0);
        add(0, 1, 5'b00101, 2, 0, 1, 0, 1, 1);
        add(0, 1, 5'b10000, 4, 1, 1, 0, 0, 1);
        add(0, 1, 5'b00000, 4, 0, 1, 0, 1, 2);
        add(0, 0, 5'b00000, 4, 0, 1, 0, 0, 2);
        add(0, 1, 5'b00000, 4, 0, 0, 0, 1, 3);
        add(1, 1, 5'b00000, 0, 0, 0, 0, 0, 0);
        add(0, 1, 5'b10000, 4, 1, 0, 0, 0, 0);
        add(0, 1, 5'b01000, 3, 1, 0, 0, 0, 0);
        add(0, 1, 5'b00100, 2, 1, 1, 1, 0, 0);
        add(0, 1, 5'b00010, 1, 1, 1, 1, 0, 0);
        add(0, 1, 5'b00001, 0, 1, 1, 1, 0, 0);
        add(0, 1, 5'b10000, 4, 1, 1, 1, 0, 0);
        add(0, 1, 5'b00010, 1, 1, 1, 1, 1, 1);
        add(1, 1, 5'b00100, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].vld, tbl[i].ring);
            chk($sformatf("vec%0d.pos", i), int'(pos), tbl[i].pos);
            chk($sformatf("vec%0d.pos_valid", i), int'(pos_valid), int'(tbl[i].pv));
            chk($sformatf("vec%0d.locked", i), int'(locked), int'(tbl[i].lk));
            chk($sformatf("vec%0d.dir", i), int'(dir), int'(tbl[i].dr));
            chk($sformatf("vec%0d.err", i), int'(err), int'(tbl[i].er));
            chk($sformatf("vec%0d.err_total", i), int'(err_total), tbl[i].tot);
        end

        // err_total saturation: repeated lock / double fault rounds.
        for (int n = 0; n < 130; n++) begin
            step(0, 1, 5'b00001); step(0, 1, 5'b00010); step(0, 1, 5'b00100);
            step(0, 1, 5'b00000); cmp_model("sat");
            step(0, 1, 5'b00000); cmp_model("sat");
        end
        chk("sat.total255", int'(err_total), 255);
        step(0, 1, 5'b00001); step(0, 1, 5'b00010); step(0, 1, 5'b00100);
        chk("sat.relock", int'(locked), 1);
        step(0, 1, 5'b11000);
        chk("sat.err_pulse", int'(err), 1);
        chk("sat.hold255", int'(err_total), 255);
        step(1, 0, 5'b00000);
        cmp_model("sat.clear");

        // Randomized rotation with faults, gaps, reversals and occasional clear.
        tok = 0; gd = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 999);
            v = ($urandom_range(0, 99) < 85);
            k = $urandom_range(0, 99);
            if (v) tok = (tok + (gd ? N - 1 : 1)) % N;
            if (k < 80)      w = 5'(1 << tok);
            else if (k < 85) w = 5'b00000;
            else if (k < 90) w = 5'($urandom_range(0, 31));
            else if (k < 93) begin gd = ~gd; w = 5'(1 << tok); end
            else             w = 5'(1 << $urandom_range(0, N - 1));
            step(r < 5, v, w);
            cmp_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
